// File: rtl/ritc_servo_dac_pkg.sv
// Shared types and helpers for the RITC VDD servo DAC path.
package ritc_servo_dac_pkg;

   localparam int FRAME_W = 16;
   localparam int DATA_W  = 12;

   localparam logic CH_R0 = 1'b0;
   localparam logic CH_R1 = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_GAP,
      ST_LDAC,
      ST_DONE
   } servo_state_t;

   // DAC word: command in [15:13], channel select in [12], data in [11:0].
   function automatic logic [FRAME_W-1:0] build_frame(input logic [2:0]        cmd,
                                                      input logic              chan,
                                                      input logic [DATA_W-1:0] val);
      return {cmd, chan, val};
   endfunction

endpackage

// File: rtl/ritc_spi_frame_tx.sv
// Shifts one 16-bit word MSB-first on a mode-0 SPI link; CS/SCLK/SDI are all registered.
module ritc_spi_frame_tx
   import ritc_servo_dac_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic               user_clk_i,
   input  logic               rst_n,
   input  logic               start,
   input  logic [FRAME_W-1:0] word,
   output logic               cs_n,
   output logic               sclk,
   output logic               sdi,
   output logic               frame_done
);

   localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);

   logic         active;
   logic [14:0]  shreg;
   logic [3:0]   bit_cnt;
   logic [7:0]   div_cnt;

   // High during the final high-phase cycle, so the sequencer leaves SHIFT as CS rises.
   assign frame_done = active && sclk && (div_cnt == 8'd0) && (bit_cnt == 4'd0);

   always_ff @(posedge user_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         active  <= 1'b0;
         cs_n    <= 1'b1;
         sclk    <= 1'b0;
         sdi     <= 1'b0;
         shreg   <= '0;
         bit_cnt <= 4'd0;
         div_cnt <= 8'd0;
      end else if (start) begin
         active  <= 1'b1;
         cs_n    <= 1'b0;
         sclk    <= 1'b0;
         sdi     <= word[FRAME_W-1];
         shreg   <= word[14:0];
         bit_cnt <= 4'd15;
         div_cnt <= DIV_LOAD;
      end else if (active) begin
         if (div_cnt != 8'd0) begin
            div_cnt <= div_cnt - 8'd1;
         end else begin
            div_cnt <= DIV_LOAD;
            if (!sclk) begin
               sclk <= 1'b1;
            end else if (bit_cnt == 4'd0) begin
               active <= 1'b0;
               cs_n   <= 1'b1;
               sclk   <= 1'b0;
               sdi    <= 1'b0;
            end else begin
               sclk    <= 1'b0;
               sdi     <= shreg[14];
               shreg   <= {shreg[13:0], 1'b0};
               bit_cnt <= bit_cnt - 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/ritc_vdd_servo_dac.sv
// Stages R0/R1 VDD servo values and commits both to the dual SPI DAC with a shared LDAC.
//
// state    | meaning
// IDLE     | waiting for an update edge or a pending request
// LOAD     | copy staging into shadow, kick off channel A frame
// SHIFT    | SPI frame in flight
// GAP      | CS high between frames / before LDAC
// LDAC     | LDAC_n held low, committed values published
// DONE     | done pulse, count transfer, re-run if a request arrived meanwhile
module ritc_vdd_servo_dac
   import ritc_servo_dac_pkg::*;
#(
   parameter int          CLK_DIV     = 4,
   parameter logic [2:0]  CMD_WRITE   = 3'b000,
   parameter int          CS_GAP      = 4,
   parameter int          LDAC_WIDTH  = 2,
   parameter logic [15:0] COUNT_RESET = 16'h0000
) (
   input  logic              user_clk_i,
   input  logic              user_rst_n_i,
   input  logic              servo_addr_i,
   input  logic              servo_wr_i,
   input  logic              servo_update_i,
   input  logic [DATA_W-1:0] servo_i,
   output logic              dac_cs_n_o,
   output logic              dac_sclk_o,
   output logic              dac_sdi_o,
   output logic              dac_ldac_n_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] vdd_r0_o,
   output logic [DATA_W-1:0] vdd_r1_o,
   output logic [15:0]       update_count_o
);

   localparam logic [7:0] GAP_LOAD  = 8'(CS_GAP - 1);
   localparam logic [7:0] LDAC_LOAD = 8'(LDAC_WIDTH - 1);

   logic [1:0]         rst_sync;
   logic               rst_n;
   servo_state_t       state;
   logic [DATA_W-1:0]  stage_r0, stage_r1;
   logic [DATA_W-1:0]  shadow_r0, shadow_r1;
   logic               upd_hist, edge_q, pending, chan;
   logic [7:0]         gap_cnt, ldac_cnt;
   logic               tx_start, frame_done;
   logic [FRAME_W-1:0] tx_word;

   always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
      if (!user_rst_n_i) rst_sync <= 2'b00;
      else               rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   always_ff @(posedge user_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         stage_r0 <= '0;
         stage_r1 <= '0;
      end else if (servo_wr_i) begin
         if (servo_addr_i == CH_R1) stage_r1 <= servo_i;
         else                       stage_r0 <= servo_i;
      end
   end

   // History resets high so a level already high at reset release is not an edge.
   always_ff @(posedge user_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         upd_hist <= 1'b1;
         edge_q   <= 1'b0;
      end else begin
         upd_hist <= servo_update_i;
         edge_q   <= servo_update_i & ~upd_hist;
      end
   end

   // Channel A frame is built from staging in LOAD since shadow lands on the same edge.
   always_comb begin
      tx_start = 1'b0;
      tx_word  = build_frame(CMD_WRITE, CH_R1, shadow_r1);
      if (state == ST_LOAD) begin
         tx_start = 1'b1;
         tx_word  = build_frame(CMD_WRITE, CH_R0, stage_r0);
      end else if (state == ST_GAP && gap_cnt == 8'd0 && chan == CH_R0) begin
         tx_start = 1'b1;
      end
   end

   ritc_spi_frame_tx #(.CLK_DIV(CLK_DIV)) u_tx (
      .user_clk_i (user_clk_i),
      .rst_n      (rst_n),
      .start      (tx_start),
      .word       (tx_word),
      .cs_n       (dac_cs_n_o),
      .sclk       (dac_sclk_o),
      .sdi        (dac_sdi_o),
      .frame_done (frame_done)
   );

   always_ff @(posedge user_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         shadow_r0      <= '0;
         shadow_r1      <= '0;
         pending        <= 1'b0;
         chan           <= CH_R0;
         gap_cnt        <= 8'd0;
         ldac_cnt       <= 8'd0;
         dac_ldac_n_o   <= 1'b1;
         busy_o         <= 1'b0;
         done_o         <= 1'b0;
         vdd_r0_o       <= '0;
         vdd_r1_o       <= '0;
         update_count_o <= COUNT_RESET;
      end else begin
         done_o <= 1'b0;
         if (edge_q) pending <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (edge_q || pending) begin
                  state   <= ST_LOAD;
                  busy_o  <= 1'b1;
                  pending <= 1'b0;
               end
            end
            ST_LOAD: begin
               shadow_r0 <= stage_r0;
               shadow_r1 <= stage_r1;
               chan      <= CH_R0;
               state     <= ST_SHIFT;
            end
            ST_SHIFT: begin
               if (frame_done) begin
                  gap_cnt <= GAP_LOAD;
                  state   <= ST_GAP;
               end
            end
            ST_GAP: begin
               if (gap_cnt != 8'd0) begin
                  gap_cnt <= gap_cnt - 8'd1;
               end else if (chan == CH_R0) begin
                  chan  <= CH_R1;
                  state <= ST_SHIFT;
               end else begin
                  dac_ldac_n_o <= 1'b0;
                  ldac_cnt     <= LDAC_LOAD;
                  vdd_r0_o     <= shadow_r0;
                  vdd_r1_o     <= shadow_r1;
                  state        <= ST_LDAC;
               end
            end
            ST_LDAC: begin
               if (ldac_cnt != 8'd0) begin
                  ldac_cnt <= ldac_cnt - 8'd1;
               end else begin
                  dac_ldac_n_o <= 1'b1;
                  done_o       <= 1'b1;
                  state        <= ST_DONE;
               end
            end
            ST_DONE: begin
               update_count_o <= update_count_o + 16'd1;
               if (pending || edge_q) begin
                  pending <= 1'b0;
                  state   <= ST_LOAD;
               end else begin
                  busy_o <= 1'b0;
                  state  <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ritc_vdd_servo_dac.sv
// Directed bench for ritc_vdd_servo_dac: default timing instance plus a CLK_DIV=1 instance.
module tb_ritc_vdd_servo_dac;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        addr = 1'b0, wr = 1'b0, upd = 1'b0;
   logic [11:0] sval = '0;
   logic        cs_n, sclk, sdi, ldac_n, busy, done;
   logic [11:0] vdd0, vdd1;
   logic [15:0] cnt;

   logic        f_addr = 1'b0, f_wr = 1'b0, f_upd = 1'b0;
   logic [11:0] f_sval = '0;
   logic        f_cs_n, f_sclk, f_sdi, f_ldac_n, f_busy, f_done;
   logic [11:0] f_vdd0, f_vdd1;
   logic [15:0] f_cnt;

   int unsigned cyc = 0;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ritc_vdd_servo_dac dut (
      .user_clk_i(clk), .user_rst_n_i(rst_n), .servo_addr_i(addr), .servo_wr_i(wr),
      .servo_update_i(upd), .servo_i(sval), .dac_cs_n_o(cs_n), .dac_sclk_o(sclk),
      .dac_sdi_o(sdi), .dac_ldac_n_o(ldac_n), .busy_o(busy), .done_o(done),
      .vdd_r0_o(vdd0), .vdd_r1_o(vdd1), .update_count_o(cnt)
   );

   ritc_vdd_servo_dac #(.CLK_DIV(1), .COUNT_RESET(16'hFFFF)) dut_f (
      .user_clk_i(clk), .user_rst_n_i(rst_n), .servo_addr_i(f_addr), .servo_wr_i(f_wr),
      .servo_update_i(f_upd), .servo_i(f_sval), .dac_cs_n_o(f_cs_n), .dac_sclk_o(f_sclk),
      .dac_sdi_o(f_sdi), .dac_ldac_n_o(f_ldac_n), .busy_o(f_busy), .done_o(f_done),
      .vdd_r0_o(f_vdd0), .vdd_r1_o(f_vdd1), .update_count_o(f_cnt)
   );

   // SPI capture for the default instance
   logic [15:0] cap = '0;
   int          nbits = 0;
   logic        prev_sclk = 1'b0, prev_cs = 1'b1;
   int          cs_falls = 0, ldac_lo = 0;
   logic [15:0] frames[$];
   int          bits_q[$];

   always @(negedge clk) begin
      prev_sclk <= sclk;
      prev_cs   <= cs_n;
      if (!cs_n && sclk && !prev_sclk) begin
         cap   <= {cap[14:0], sdi};
         nbits <= nbits + 1;
      end
      if (!cs_n && prev_cs) begin
         nbits    <= 0;
         cs_falls <= cs_falls + 1;
      end
      if (cs_n && !prev_cs) begin
         frames.push_back(cap);
         bits_q.push_back(nbits);
      end
      if (!ldac_n) ldac_lo <= ldac_lo + 1;
   end

   // SPI capture for the CLK_DIV=1 instance
   logic [15:0] f_cap = '0;
   int          f_nbits = 0;
   logic        f_prev_sclk = 1'b0, f_prev_cs = 1'b1;
   int unsigned f_last_rise = 0, f_rise_period = 0;
   logic [15:0] f_frames[$];
   int          f_bits_q[$];

   always @(negedge clk) begin
      f_prev_sclk <= f_sclk;
      f_prev_cs   <= f_cs_n;
      if (!f_cs_n && f_sclk && !f_prev_sclk) begin
         f_cap         <= {f_cap[14:0], f_sdi};
         f_nbits       <= f_nbits + 1;
         f_last_rise   <= cyc;
         f_rise_period <= cyc - f_last_rise;
      end
      if (!f_cs_n && f_prev_cs) f_nbits <= 0;
      if (f_cs_n && !f_prev_cs) begin
         f_frames.push_back(f_cap);
         f_bits_q.push_back(f_nbits);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic go_to(input int unsigned t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic wr_stage(input logic a, input logic [11:0] v);
      addr = a; sval = v; wr = 1'b1;
      @(negedge clk);
      wr = 1'b0;
   endtask

   task automatic f_wr_stage(input logic a, input logic [11:0] v);
      f_addr = a; f_sval = v; f_wr = 1'b1;
      @(negedge clk);
      f_wr = 1'b0;
   endtask

   task automatic wait_done(input bit fast, input int budget, output int unsigned t);
      int k = 0;
      while ((fast ? f_done : done) !== 1'b1 && k < budget) begin
         @(negedge clk);
         k++;
      end
      t = cyc;
      chk(fast ? "f_done_seen" : "done_seen", fast ? f_done : done, 1);
   endtask

   int unsigned c0, t, t2;
   int          fi, lb, cf, dn;

   initial begin
      // reset values
      repeat (3) @(negedge clk);
      chk("rst_cs_n", cs_n, 1);
      chk("rst_sclk", sclk, 0);
      chk("rst_sdi", sdi, 0);
      chk("rst_ldac_n", ldac_n, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_vdd0", vdd0, 0);
      chk("rst_vdd1", vdd1, 0);
      chk("rst_count", cnt, 0);
      chk("rst_f_count", f_cnt, 16'hFFFF);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // basic transfer
      wr_stage(1'b0, 12'h5A3);
      wr_stage(1'b1, 12'h0FF);
      fi = frames.size(); lb = ldac_lo;
      upd = 1'b1; c0 = cyc;
      go_to(c0 + 2);
      chk("load_busy", busy, 1);
      chk("load_cs_n", cs_n, 1);
      go_to(c0 + 3);
      chk("first_shift_cs_n", cs_n, 0);
      wait_done(1'b0, 400, t);
      chk("t1_latency", t - c0, 269);
      @(negedge clk);
      chk("t1_done_pulse", done, 0);
      chk("t1_busy_clear", busy, 0);
      chk("t1_count", cnt, 1);
      chk("t1_vdd0", vdd0, 12'h5A3);
      chk("t1_vdd1", vdd1, 12'h0FF);
      chk("t1_nframes", frames.size() - fi, 2);
      chk("t1_frame_a", frames[fi], 16'h05A3);
      chk("t1_frame_b", frames[fi+1], 16'h10FF);
      chk("t1_bits_a", bits_q[fi], 16);
      chk("t1_bits_b", bits_q[fi+1], 16);
      chk("t1_ldac_cycles", ldac_lo - lb, 2);
      upd = 1'b0;

      // write in the same cycle the update edge is sampled
      repeat (2) @(negedge clk);
      fi = frames.size();
      addr = 1'b1; sval = 12'h800; wr = 1'b1; upd = 1'b1; c0 = cyc;
      @(negedge clk);
      wr = 1'b0;
      wait_done(1'b0, 400, t);
      chk("t2_latency", t - c0, 269);
      @(negedge clk);
      chk("t2_frame_a", frames[fi], 16'h05A3);
      chk("t2_frame_b", frames[fi+1], 16'h1800);
      chk("t2_count", cnt, 2);
      chk("t2_vdd1", vdd1, 12'h800);
      upd = 1'b0;

      // three edges while busy coalesce into one extra transfer
      repeat (2) @(negedge clk);
      fi = frames.size();
      upd = 1'b1; c0 = cyc;
      go_to(c0 + 20); upd = 1'b0;
      go_to(c0 + 22); upd = 1'b1;
      go_to(c0 + 24); upd = 1'b0;
      go_to(c0 + 26); upd = 1'b1;
      go_to(c0 + 28); upd = 1'b0;
      go_to(c0 + 30); upd = 1'b1;
      go_to(c0 + 32); upd = 1'b0;
      go_to(c0 + 50);
      wr_stage(1'b0, 12'h123);
      wait_done(1'b0, 400, t);
      chk("t3_latency", t - c0, 269);
      @(negedge clk);
      chk("t3_busy_held", busy, 1);
      chk("t3_count_mid", cnt, 3);
      wait_done(1'b0, 400, t2);
      chk("t3_rerun_latency", t2 - t, 268);
      @(negedge clk);
      chk("t3_count", cnt, 4);
      dn = cs_falls;
      repeat (400) @(negedge clk);
      chk("t3_no_third", cs_falls - dn, 0);
      chk("t3_nframes", frames.size() - fi, 4);
      chk("t3_frame0", frames[fi], 16'h05A3);
      chk("t3_frame1", frames[fi+1], 16'h1800);
      chk("t3_frame2", frames[fi+2], 16'h0123);
      chk("t3_frame3", frames[fi+3], 16'h1800);
      chk("t3_vdd0", vdd0, 12'h123);

      // update held high through reset release
      upd = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("t4_count_rst", cnt, 0);
      rst_n = 1'b1;
      cf = cs_falls;
      repeat (300) @(negedge clk);
      chk("t4_no_cs", cs_falls - cf, 0);
      chk("t4_idle_busy", busy, 0);
      wr_stage(1'b0, 12'h5A3);
      wr_stage(1'b1, 12'h0FF);
      upd = 1'b0;
      repeat (2) @(negedge clk);
      fi = frames.size();
      upd = 1'b1; c0 = cyc;
      wait_done(1'b0, 400, t);
      chk("t4_latency", t - c0, 269);
      @(negedge clk);
      chk("t4_count", cnt, 1);
      chk("t4_vdd0", vdd0, 12'h5A3);
      chk("t4_vdd1", vdd1, 12'h0FF);
      chk("t4_frame_a", frames[fi], 16'h05A3);
      chk("t4_frame_b", frames[fi+1], 16'h10FF);

      // reset in the middle of bit 7 of the first frame
      upd = 1'b0;
      repeat (2) @(negedge clk);
      upd = 1'b1; c0 = cyc;
      go_to(c0 + 57);
      chk("t5_pre_cs_n", cs_n, 0);
      chk("t5_pre_sclk", sclk, 1);
      rst_n = 1'b0;
      #1;
      chk("t5_cs_n", cs_n, 1);
      chk("t5_sclk", sclk, 0);
      chk("t5_sdi", sdi, 0);
      chk("t5_ldac_n", ldac_n, 1);
      chk("t5_busy", busy, 0);
      chk("t5_vdd0", vdd0, 0);
      chk("t5_vdd1", vdd1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      upd = 1'b0;
      repeat (4) @(negedge clk);

      // CLK_DIV=1 instance with counter wrap
      chk("t6_count_rst", f_cnt, 16'hFFFF);
      f_wr_stage(1'b0, 12'hABC);
      f_wr_stage(1'b1, 12'h321);
      fi = f_frames.size();
      f_upd = 1'b1; c0 = cyc;
      wait_done(1'b1, 200, t);
      chk("t6_latency", t - c0, 77);
      @(negedge clk);
      chk("t6_count_wrap", f_cnt, 16'h0000);
      chk("t6_vdd0", f_vdd0, 12'hABC);
      chk("t6_vdd1", f_vdd1, 12'h321);
      chk("t6_frame_a", f_frames[fi], 16'h0ABC);
      chk("t6_frame_b", f_frames[fi+1], 16'h1321);
      chk("t6_bits_a", f_bits_q[fi], 16);
      chk("t6_sclk_period", f_rise_period, 2);
      f_upd = 1'b0;

      repeat (4) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ritc_vdd_servo_dac.md
Name: ritc_vdd_servo_dac

Overview:
- Receiving end of the phase scanner's servo interface (servo address, write, update and 12-bit value).
- Stages one 12-bit VDD servo value per RITC (R0, R1).
- On an update request, shifts both values to a dual-channel 12-bit SPI DAC as two 16-bit frames, then pulses LDAC_n so both outputs change together.
- Sits between the phase-scanner PicoBlaze glue and the board VDD DAC pins.

Parameters:
- CLK_DIV, 4: half-period of SCLK in user_clk_i cycles; SCLK = f_clk/(2*CLK_DIV); legal range 1..255.
- CMD_WRITE, 3'b000: DAC command bits placed in frame[15:13].
- CS_GAP, 4: cycles with dac_cs_n_o high between frames and before LDAC; minimum 1.
- LDAC_WIDTH, 2: cycles dac_ldac_n_o is held low; minimum 1.

Ports:
- user_clk_i  in  1  sole clock.
- user_rst_n_i  in  1  asynchronous, active-low reset.
- servo_addr_i  in  1  staging slot select for write (0 = R0, 1 = R1).
- servo_wr_i  in  1  one-cycle pulse; writes servo_i into the slot selected by servo_addr_i.
- servo_update_i  in  1  level; a 0->1 transition requests a DAC transfer.
- servo_i  in  12  value to stage.
- dac_cs_n_o  out  1  SPI chip select, active low.
- dac_sclk_o  out  1  SPI clock; idles low.
- dac_sdi_o  out  1  SPI data, MSB first.
- dac_ldac_n_o  out  1  DAC load strobe, active low.
- busy_o  out  1  high from LOAD through DONE.
- done_o  out  1  one-cycle pulse when a transfer completes.
- vdd_r0_o  out  12  last value committed to DAC channel A.
- vdd_r1_o  out  12  last value committed to DAC channel B.
- update_count_o  out  16  completed transfers; wraps 0xFFFF -> 0.

Behaviour:
- Reset (async assert, sync deassert internally):
  - dac_cs_n_o=1, dac_sclk_o=0, dac_sdi_o=0, dac_ldac_n_o=1, busy_o=0, done_o=0.
  - Staging, shadow, vdd_r*_o, update_count_o all 0; pending=0.
  - Edge-detect history register resets to 1, so update held high through reset release starts nothing.
- Reset mid-transfer: all outputs return to reset values immediately; the partial frame is abandoned.
- Staging: on servo_wr_i, stage[servo_addr_i] <= servo_i. Writes are accepted in every state and affect staging only.
- Edge detect: cycle N samples servo_update_i=1 with history=0 -> registered edge at N+1.
- FSM states: IDLE, LOAD, SHIFT, GAP, LDAC, DONE.
  - IDLE: an edge moves to LOAD.
  - LOAD (1 cycle): shadow <= stage (includes any write made in cycle N); channel index=0; busy_o=1.
  - SHIFT:
    - Frame = {CMD_WRITE, chan, shadow[chan]}, 16 bits.
    - dac_cs_n_o low with MSB on dac_sdi_o on the first SHIFT cycle (N+3).
    - Each bit: SCLK low for CLK_DIV cycles, then high for CLK_DIV cycles. sdi changes only at the falling edge or frame start, so the DAC samples on the rising edge.
    - After the 16th high phase, SCLK returns low and dac_cs_n_o goes high -> GAP.
  - GAP (CS_GAP cycles): if chan=0, set chan=1 -> SHIFT; else -> LDAC.
  - LDAC: dac_ldac_n_o low for LDAC_WIDTH cycles; vdd_r0_o/vdd_r1_o <= shadow on entry -> DONE.
  - DONE (1 cycle): done_o=1; update_count_o+1; if pending, clear it -> LOAD, else -> IDLE.
- Update edges from LOAD through DONE set pending. Multiple edges coalesce into one extra transfer using the latest staging.
- A new edge in the DONE cycle also sets pending.
- Timing at CLK_DIV=4, CS_GAP=4, LDAC_WIDTH=2: frame = 128 cycles; edge sample (N) to done_o = 2+128+4+128+4+2+1 -> done_o at N+269.
- sclk, sdi, cs_n and ldac_n come straight from registers; no glitches.

Decomposition:
- Package ritc_servo_dac_pkg:
  - state enum;
  - FRAME_W=16, DATA_W=12;
  - channel constants CH_R0=0, CH_R1=1;
  - frame-assembly function.
- One sub-module, ritc_spi_frame_tx:
  - takes a 16-bit word with a start pulse;
  - generates CS/SCLK/SDI using CLK_DIV;
  - returns a frame_done pulse.
- Top level holds staging, edge detect, pending logic and the sequencing FSM.

Test Plan:
- Reset, then write R0=0x5A3 and R1=0x0FF, then raise update -> SDI frames 0x05A3 then 0x10FF MSB-first, 16 rising SCLK per frame; LDAC_n low 2 cycles; done_o at edge+269; vdd_r0_o=0x5A3, vdd_r1_o=0x0FF; count=1.
- servo_wr_i with addr=1, value 0x800 in the same cycle update first reads high -> second frame carries 0x1800.
- Three update edges during busy with R0 rewritten to 0x123 -> exactly one extra transfer sending 0x0123; count=2; no third.
- Hold update high across reset release -> no CS activity; a later 0->1 toggle starts one transfer.
- Assert reset mid-frame 7 -> cs_n=1, sclk=0, ldac_n=1, busy=0 same cycle; vdd_r*_o=0.
- CLK_DIV=1 and preset count 0xFFFF -> SCLK period 2 cycles, frames correct; count wraps to 0x0000.
